// File: rtl/dispatch_router_if.sv
// Decode-to-dispatch bus for dispatch_router: instruction operands and decode
// fields on the way in, one registered queue packet plus credit returns on the
// way out. The master modport is the decode/queue side; slave is the router.
interface dispatch_router_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   immediate;
    logic [XLEN-1:0]   jmp_br_addr;
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [TAG_W:0]    rs1_tag;
    logic [TAG_W:0]    rs2_tag;
    logic [TAG_W-1:0]  rd_tag;
    logic              flush;
    logic [3:0]        q_valid;
    logic [6:0]        q_opcode;
    logic [2:0]        q_func3;
    logic [6:0]        q_func7;
    logic [XLEN-1:0]   q_rs1_data;
    logic [XLEN-1:0]   q_rs2_data;
    logic              q_rs1_dv;
    logic              q_rs2_dv;
    logic [TAG_W:0]    q_rs1_tag;
    logic [TAG_W:0]    q_rs2_tag;
    logic [TAG_W-1:0]  q_rd_tag;
    logic [XLEN-1:0]   q_imm;
    logic [3:0]        q_credit_ret;
    logic              illegal_op;

    modport master (
        output in_valid, rs1, rs2, rs1_data, rs2_data, immediate, jmp_br_addr,
               opcode, func3, func7, rs1_tag, rs2_tag, rd_tag, flush, q_credit_ret,
        input  in_ready, q_valid, q_opcode, q_func3, q_func7, q_rs1_data, q_rs2_data,
               q_rs1_dv, q_rs2_dv, q_rs1_tag, q_rs2_tag, q_rd_tag, q_imm, illegal_op
    );

    modport slave (
        input  in_valid, rs1, rs2, rs1_data, rs2_data, immediate, jmp_br_addr,
               opcode, func3, func7, rs1_tag, rs2_tag, rd_tag, flush, q_credit_ret,
        output in_ready, q_valid, q_opcode, q_func3, q_func7, q_rs1_data, q_rs2_data,
               q_rs1_dv, q_rs2_dv, q_rs1_tag, q_rs2_tag, q_rd_tag, q_imm, illegal_op
    );
endinterface

// File: rtl/dispatch_router.sv
// dispatch_router: classifies a decoded instruction into INT / LDST / MULT / DIV,
// resolves operand readiness, and emits a registered one-hot enqueue strobe and
// packet one cycle after the transfer. Per-queue credit counters gate in_ready.
// Optional build macro DISPATCH_STALL_STATS_EN adds per-queue 16-bit saturating
// stall counters (cycles with in_valid=1, in_ready=0 aimed at that queue).
module dispatch_router #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 6,
    parameter int CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    dispatch_router_if.slave  bus
`ifdef DISPATCH_STALL_STATS_EN
    ,
    output logic [3:0][15:0]  stall_cnt
`endif
);
    typedef enum logic [2:0] {CLS_INT, CLS_LDST, CLS_MULT, CLS_DIV, CLS_ILL} cls_e;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [3:0] CRED_INIT = 4'(CREDITS);

    cls_e              cls_s;
    logic [3:0]        tgt_s;
    logic [3:0]        credit_nz_s;
    logic              ready_s;
    logic              fire_s;

    logic [3:0]        q_valid_d, q_valid_q;
    logic              illegal_d, illegal_q;
    logic [6:0]        opcode_d, opcode_q;
    logic [2:0]        func3_d, func3_q;
    logic [6:0]        func7_d, func7_q;
    logic [XLEN-1:0]   rs1_data_d, rs1_data_q;
    logic [XLEN-1:0]   rs2_data_d, rs2_data_q;
    logic              rs1_dv_d, rs1_dv_q;
    logic              rs2_dv_d, rs2_dv_q;
    logic [TAG_W:0]    rs1_tag_d, rs1_tag_q;
    logic [TAG_W:0]    rs2_tag_d, rs2_tag_q;
    logic [TAG_W-1:0]  rd_tag_d, rd_tag_q;
    logic [XLEN-1:0]   imm_d, imm_q;
    logic [3:0][3:0]   credit_d, credit_q;
`ifdef DISPATCH_STALL_STATS_EN
    logic [3:0][15:0]  stall_d, stall_q;
`endif

    // Classify the incoming instruction and derive its one-hot target queue.
    always_comb begin
        cls_s = CLS_ILL;
        case (bus.opcode)
            OP_R: begin
                if (bus.func7 == 7'd1 && bus.func3 == 3'd0) begin
                    cls_s = CLS_MULT;
                end else if (bus.func7 == 7'd1 && bus.func3 == 3'd4) begin
                    cls_s = CLS_DIV;
                end else begin
                    cls_s = CLS_INT;
                end
            end
            OP_IMM, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: cls_s = CLS_INT;
            OP_LOAD, OP_STORE:                                    cls_s = CLS_LDST;
            default:                                              cls_s = CLS_ILL;
        endcase
        case (cls_s)
            CLS_INT:  tgt_s = 4'b0001;
            CLS_LDST: tgt_s = 4'b0010;
            CLS_MULT: tgt_s = 4'b0100;
            CLS_DIV:  tgt_s = 4'b1000;
            default:  tgt_s = 4'b0000;
        endcase
        for (int i = 0; i < 4; i++) begin
            credit_nz_s[i] = (credit_q[i] != 4'd0);
        end
        // Illegal opcodes are always accepted; only the target queue's credit matters.
        ready_s = ~rst & ~bus.flush & ((cls_s == CLS_ILL) | (|(tgt_s & credit_nz_s)));
        fire_s  = bus.in_valid & ready_s;
    end

    // Next-state for the output stage, operand readiness and credit counters.
    always_comb begin
        q_valid_d  = fire_s ? tgt_s : 4'b0000;
        illegal_d  = fire_s & (cls_s == CLS_ILL);
        opcode_d   = opcode_q;
        func3_d    = func3_q;
        func7_d    = func7_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rs1_dv_d   = rs1_dv_q;
        rs2_dv_d   = rs2_dv_q;
        rs1_tag_d  = rs1_tag_q;
        rs2_tag_d  = rs2_tag_q;
        rd_tag_d   = rd_tag_q;
        imm_d      = imm_q;
        if (fire_s && cls_s != CLS_ILL) begin
            opcode_d  = bus.opcode;
            func3_d   = bus.func3;
            func7_d   = bus.func7;
            rs1_tag_d = bus.rs1_tag;
            rs2_tag_d = bus.rs2_tag;
            rd_tag_d  = bus.rd_tag;
            // x0 is always a ready zero; otherwise ready means the tag is not pending.
            if (bus.rs1 == 5'd0) begin
                rs1_data_d = {XLEN{1'b0}};
                rs1_dv_d   = 1'b1;
            end else begin
                rs1_data_d = bus.rs1_data;
                rs1_dv_d   = ~bus.rs1_tag[TAG_W];
            end
            if (bus.opcode == OP_IMM) begin
                rs2_data_d = bus.immediate;
                rs2_dv_d   = 1'b1;
            end else if (bus.rs2 == 5'd0) begin
                rs2_data_d = {XLEN{1'b0}};
                rs2_dv_d   = 1'b1;
            end else begin
                rs2_data_d = bus.rs2_data;
                rs2_dv_d   = ~bus.rs2_tag[TAG_W] | (bus.opcode == OP_LOAD);
            end
            imm_d = (cls_s == CLS_LDST) ? bus.jmp_br_addr : bus.immediate;
        end else begin
            imm_d = imm_q;
        end
        for (int i = 0; i < 4; i++) begin
            logic [4:0] sum;
            sum = {1'b0, credit_q[i]} + {4'd0, bus.q_credit_ret[i]} - {4'd0, q_valid_d[i]};
            credit_d[i] = (sum > {1'b0, CRED_INIT}) ? CRED_INIT : sum[3:0];
        end
`ifdef DISPATCH_STALL_STATS_EN
        for (int i = 0; i < 4; i++) begin
            if (bus.in_valid && !ready_s && tgt_s[i] && stall_q[i] != 16'hFFFF) begin
                stall_d[i] = stall_q[i] + 16'd1;
            end else begin
                stall_d[i] = stall_q[i];
            end
        end
`endif
    end

    // Output register stage and credit state, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid_q  <= 4'b0000;
            illegal_q  <= 1'b0;
            opcode_q   <= 7'd0;
            func3_q    <= 3'd0;
            func7_q    <= 7'd0;
            rs1_data_q <= {XLEN{1'b0}};
            rs2_data_q <= {XLEN{1'b0}};
            rs1_dv_q   <= 1'b0;
            rs2_dv_q   <= 1'b0;
            rs1_tag_q  <= {(TAG_W+1){1'b0}};
            rs2_tag_q  <= {(TAG_W+1){1'b0}};
            rd_tag_q   <= {TAG_W{1'b0}};
            imm_q      <= {XLEN{1'b0}};
            credit_q   <= {4{CRED_INIT}};
`ifdef DISPATCH_STALL_STATS_EN
            stall_q    <= {4{16'd0}};
`endif
        end else begin
            q_valid_q  <= q_valid_d;
            illegal_q  <= illegal_d;
            opcode_q   <= opcode_d;
            func3_q    <= func3_d;
            func7_q    <= func7_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rs1_dv_q   <= rs1_dv_d;
            rs2_dv_q   <= rs2_dv_d;
            rs1_tag_q  <= rs1_tag_d;
            rs2_tag_q  <= rs2_tag_d;
            rd_tag_q   <= rd_tag_d;
            imm_q      <= imm_d;
            credit_q   <= credit_d;
`ifdef DISPATCH_STALL_STATS_EN
            stall_q    <= stall_d;
`endif
        end
    end

    assign bus.in_ready   = ready_s;
    assign bus.q_valid    = q_valid_q;
    assign bus.illegal_op = illegal_q;
    assign bus.q_opcode   = opcode_q;
    assign bus.q_func3    = func3_q;
    assign bus.q_func7    = func7_q;
    assign bus.q_rs1_data = rs1_data_q;
    assign bus.q_rs2_data = rs2_data_q;
    assign bus.q_rs1_dv   = rs1_dv_q;
    assign bus.q_rs2_dv   = rs2_dv_q;
    assign bus.q_rs1_tag  = rs1_tag_q;
    assign bus.q_rs2_tag  = rs2_tag_q;
    assign bus.q_rd_tag   = rd_tag_q;
    assign bus.q_imm      = imm_q;
`ifdef DISPATCH_STALL_STATS_EN
    assign stall_cnt      = stall_q;
`endif
endmodule
